// File: rtl/ae_pkg.sv
// Shared types and defaults for the auto-exposure controller.
// Holds the FSM state enum and the saturating dead-band helper.
package ae_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    WAIT,
    CALC,
    REQ,
    SETTLE
  } ae_state_t;

  localparam int AE_EXP_W         = 16;
  localparam int AE_EXP_MIN       = 16;
  localparam int AE_EXP_MAX       = 4000;
  localparam int AE_EXP_INIT      = 1000;
  localparam int AE_STEP_SHIFT    = 3;
  localparam int AE_SETTLE_FRAMES = 2;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } ae_band_t;

  // Band edges computed in 33 bits so they clip instead of wrapping.
  function automatic ae_band_t ae_band(
    input logic [31:0] target,
    input logic [31:0] tol
  );
    logic [32:0] h;
    logic [32:0] l;
    ae_band_t    b;
    h    = {1'b0, target} + {1'b0, tol};
    l    = {1'b0, target} - {1'b0, tol};
    b.hi = h[32] ? '1 : h[31:0];
    b.lo = l[32] ? '0 : l[31:0];
    return b;
  endfunction

endpackage

// File: rtl/ae_step.sv
// Registered exposure step candidates: one step down and one step up,
// each already clamped to the legal exposure range.
module ae_step
  import ae_pkg::*;
#(
  parameter int               EXP_W      = AE_EXP_W,
  parameter logic [EXP_W-1:0] EXP_MIN    = EXP_W'(AE_EXP_MIN),
  parameter logic [EXP_W-1:0] EXP_MAX    = EXP_W'(AE_EXP_MAX),
  parameter int               STEP_SHIFT = AE_STEP_SHIFT
) (
  input  logic             c,
  input  logic [EXP_W-1:0] cur,
  output logic [EXP_W-1:0] dn,
  output logic [EXP_W-1:0] up
);

  logic [EXP_W:0] ext;
  logic [EXP_W:0] step;
  logic [EXP_W:0] sub;
  logic [EXP_W:0] add;
  logic           dn_clip;
  logic           up_clip;

  // One extra bit keeps add/subtract from wrapping ahead of the clamp.
  always_comb begin
    ext  = {1'b0, cur};
    step = ext >> STEP_SHIFT;
    if (step == '0) step = (EXP_W+1)'(1);
    sub     = ext - step;
    add     = ext + step;
    dn_clip = (ext < step) || (sub < {1'b0, EXP_MIN});
    up_clip = add > {1'b0, EXP_MAX};
  end

  always_ff @(posedge c) begin
    dn <= dn_clip ? EXP_MIN : sub[EXP_W-1:0];
    up <= up_clip ? EXP_MAX : add[EXP_W-1:0];
  end

endmodule

// File: rtl/auto_exposure.sv
// Closed-loop exposure controller: frame totals from accumulator
// snapshots, dead-band compare, req/ack exposure write, settle window.
module auto_exposure
  import ae_pkg::*;
#(
  parameter int               EXP_W         = AE_EXP_W,
  parameter logic [EXP_W-1:0] EXP_MIN       = EXP_W'(AE_EXP_MIN),
  parameter logic [EXP_W-1:0] EXP_MAX       = EXP_W'(AE_EXP_MAX),
  parameter logic [EXP_W-1:0] EXP_INIT      = EXP_W'(AE_EXP_INIT),
  parameter int               STEP_SHIFT    = AE_STEP_SHIFT,
  parameter int               SETTLE_FRAMES = AE_SETTLE_FRAMES
) (
  input  logic             c,
  input  logic             rst,
  input  logic             en,
  input  logic [31:0]      sum,
  input  logic             frame_end,
  input  logic [31:0]      target,
  input  logic [31:0]      tol,
  output logic [EXP_W-1:0] exp_val,
  output logic             exp_wr_req,
  input  logic             exp_wr_ack,
  output logic [31:0]      frame_sum,
  output logic             locked
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_FRAMES - 1);

  ae_state_t        state;
  logic [31:0]      sum_prev;
  logic [3:0]       settle_cnt;
  logic [EXP_W-1:0] exp_dn;
  logic [EXP_W-1:0] exp_up;
  ae_band_t         band;

  assign band = ae_band(target, tol);

  ae_step #(
    .EXP_W      (EXP_W),
    .EXP_MIN    (EXP_MIN),
    .EXP_MAX    (EXP_MAX),
    .STEP_SHIFT (STEP_SHIFT)
  ) u_step (
    .c   (c),
    .cur (exp_val),
    .dn  (exp_dn),
    .up  (exp_up)
  );

  always_ff @(posedge c) begin
    if (rst) begin
      state      <= IDLE;
      sum_prev   <= '0;
      frame_sum  <= '0;
      exp_val    <= EXP_INIT;
      exp_wr_req <= 1'b0;
      locked     <= 1'b0;
      settle_cnt <= '0;
    end else begin
      if (frame_end && state != IDLE) begin
        sum_prev <= sum;
        if (state != PRIME) frame_sum <= sum - sum_prev;
      end
      unique case (state)
        IDLE: if (en) state <= PRIME;
        PRIME: begin
          if (!en) state <= IDLE;
          else if (frame_end) state <= WAIT;
        end
        WAIT: begin
          if (!en) state <= IDLE;
          else if (frame_end) state <= CALC;
        end
        CALC: begin
          if (!en) begin
            state <= IDLE;
          end else if (frame_sum > band.hi && exp_dn != exp_val) begin
            exp_val    <= exp_dn;
            locked     <= 1'b0;
            exp_wr_req <= 1'b1;
            state      <= REQ;
          end else if (frame_sum < band.lo && exp_up != exp_val) begin
            exp_val    <= exp_up;
            locked     <= 1'b0;
            exp_wr_req <= 1'b1;
            state      <= REQ;
          end else begin
            locked <= 1'b1;
            state  <= WAIT;
          end
        end
        // The handshake always completes, even if en has dropped.
        REQ: begin
          if (exp_wr_ack) begin
            exp_wr_req <= 1'b0;
            settle_cnt <= '0;
            state      <= en ? SETTLE : IDLE;
          end
        end
        SETTLE: begin
          if (!en) begin
            state <= IDLE;
          end else if (frame_end) begin
            if (settle_cnt == SETTLE_LAST) state <= WAIT;
            else settle_cnt <= settle_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
